// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract/negate/invert unit: a single full-adder slice walks the
// operands LSB-first, one bit per clock, behind a start/busy/done handshake.
module serial_addsub_ctrl #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic               r_carry_msb;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_load_sa;
    logic [WIDTH-1:0]   w_load_sb;
    logic               w_load_c;
    logic               w_sum;
    logic               w_cout;
    logic               w_carry_msb;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Every operation is reduced to SA + SB + cin on the one shared slice.
    always_comb begin
        w_load_sa = a;
        w_load_sb = b;
        w_load_c  = 1'b0;
        case (op)
            2'b00: begin
                w_load_sa = a;
                w_load_sb = b;
                w_load_c  = 1'b0;
            end
            2'b01: begin
                w_load_sa = a;
                w_load_sb = ~b;
                w_load_c  = 1'b1;
            end
            2'b10: begin
                w_load_sa = ~a;
                w_load_sb = '0;
                w_load_c  = 1'b1;
            end
            default: begin
                w_load_sa = ~a;
                w_load_sb = '0;
                w_load_c  = 1'b0;
            end
        endcase
    end

    assign w_sum  = r_sa[0] ^ r_sb[0] ^ r_carry;
    assign w_cout = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);

    // On the final slice the live carry is the carry into the MSB; otherwise keep the saved copy.
    assign w_carry_msb = w_last ? r_carry : r_carry_msb;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa        <= '0;
            r_sb        <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_carry_msb <= 1'b0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_sa        <= w_load_sa;
                r_sb        <= w_load_sb;
                r_carry     <= w_load_c;
                r_carry_msb <= 1'b0;
                r_acc       <= '0;
                r_cnt       <= '0;
            end else if (r_state == S_RUN) begin
                r_sa        <= {1'b0, r_sa[WIDTH-1:1]};
                r_sb        <= {1'b0, r_sb[WIDTH-1:1]};
                r_acc       <= {w_sum, r_acc[WIDTH-1:1]};
                r_carry     <= w_cout;
                r_carry_msb <= w_carry_msb;
                r_cnt       <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_result <= {w_sum, r_acc[WIDTH-1:1]};
                    r_cout   <= w_cout;
                    r_ovf    <= w_carry_msb ^ w_cout;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed table, random ops against an
// arithmetic reference model, and hand-written handshake/reset sequences.
module tb_serial_addsub_ctrl;

    localparam int W = 5;
    localparam int C = 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int n_checks;
    int n_errors;

    logic [W-1:0] last_res;
    logic         last_c;
    logic         last_v;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    serial_addsub_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model in plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [1:0] m_op, input logic [W-1:0] m_a, input logic [W-1:0] m_b);
        exp_t e;
        int   ua, ub, sa, sb, s, u;
        int   modv, smax, smin;
        modv = 1 << W;
        smax = (1 << (W - 1)) - 1;
        smin = -(1 << (W - 1));
        ua = int'(m_a);
        ub = int'(m_b);
        sa = (ua > smax) ? ua - modv : ua;
        sb = (ub > smax) ? ub - modv : ub;
        e.res  = '0;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        case (m_op)
            2'b00: begin
                u = ua + ub;
                s = sa + sb;
                e.res  = W'(u % modv);
                e.cout = (u >= modv);
                e.ovf  = (s > smax) || (s < smin);
            end
            2'b01: begin
                u = ua - ub + modv;
                s = sa - sb;
                e.res  = W'(u % modv);
                e.cout = (ua >= ub);
                e.ovf  = (s > smax) || (s < smin);
            end
            2'b10: begin
                u = modv - ua;
                s = -sa;
                e.res  = W'(u % modv);
                e.cout = (ua == 0);
                e.ovf  = (s > smax) || (s < smin);
            end
            default: begin
                e.res  = W'(modv - 1 - ua);
                e.cout = 1'b0;
                e.ovf  = 1'b0;
            end
        endcase
        return e;
    endfunction

    // Launches one op (start sampled at the next rising edge k) and checks the whole transaction.
    // Returns at the falling edge inside the done cycle.
    task automatic do_op(input logic [1:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                         input logic [W-1:0] e_res, input logic e_c, input logic e_v,
                         input bit extra, input string tag);
        int j;
        bit seen;
        bit hold_ok;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        j       = 0;
        seen    = 1'b0;
        hold_ok = 1'b1;
        while (!seen && j < 4 * W) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy || result !== last_res || carry_out !== last_c || overflow !== last_v)
                    hold_ok = 1'b0;
                if (extra && j == 1) begin
                    start = 1'b1;
                    op    = 2'b11;
                    a     = ~t_a;
                    b     = ~t_b;
                end
                if (extra && j == 2)
                    start = 1'b0;
                j++;
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, int'(seen), 1);
        check({tag, " latency"}, j, W);
        check({tag, " busy_and_hold_during_run"}, int'(hold_ok), 1);
        check({tag, " busy_at_done"}, int'(busy), 0);
        check({tag, " result"}, int'(result), int'(e_res));
        check({tag, " carry_out"}, int'(carry_out), int'(e_c));
        check({tag, " overflow"}, int'(overflow), int'(e_v));
        $display("%s: op=%b a=%b b=%b -> result=%b cout=%b ovf=%b (exp %b %b %b) lat=%0d",
                 tag, t_op, t_a, t_b, result, carry_out, overflow, e_res, e_c, e_v, j);
        last_res = e_res;
        last_c   = e_c;
        last_v   = e_v;
    endtask

    task automatic idle_gap(input string tag);
        @(negedge clk);
        check({tag, " done_single_cycle"}, int'(done), 0);
        check({tag, " idle_not_busy"}, int'(busy), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " result"}, int'(result), 0);
        check({tag, " carry_out"}, int'(carry_out), 0);
        check({tag, " overflow"}, int'(overflow), 0);
    endtask

    vec_t vecs[11];
    exp_t e;
    exp_t e2;

    initial begin
        int dones;
        int busies;
        logic [1:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;

        n_checks = 0;
        n_errors = 0;
        last_res = '0;
        last_c   = 1'b0;
        last_v   = 1'b0;

        vecs[0]  = '{2'b00, 5'b00101, 5'b00011, 5'b01000, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 5'b00101, 5'b00011, 5'b00010, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 5'b00011, 5'b00101, 5'b11110, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 5'b00000, 5'b10101, 5'b00000, 1'b1, 1'b0};
        vecs[4]  = '{2'b10, 5'b00001, 5'b11111, 5'b11111, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 5'b00101, 5'b01010, 5'b11011, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 5'b01111, 5'b00110, 5'b10001, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 5'b10000, 5'b11001, 5'b10000, 1'b0, 1'b1};
        vecs[8]  = '{2'b10, 5'b11111, 5'b00111, 5'b00001, 1'b0, 1'b0};
        vecs[9]  = '{2'b00, 5'b01111, 5'b00001, 5'b10000, 1'b0, 1'b1};
        vecs[10] = '{2'b11, 5'b00101, 5'b11100, 5'b11010, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset_idle");

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cout, vecs[i].ovf,
                  1'b0, $sformatf("vec%0d", i));
            idle_gap($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom);
            r_a  = W'($urandom);
            r_b  = W'($urandom);
            e    = model(r_op, r_a, r_b);
            do_op(r_op, r_a, r_b, e.res, e.cout, e.ovf, 1'b0, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1)
                idle_gap($sformatf("rand%0d", i));
        end

        // Start while busy must be dropped: one done, no follow-on run.
        e = model(2'b00, 5'b00110, 5'b01001);
        do_op(2'b00, 5'b00110, 5'b01001, e.res, e.cout, e.ovf, 1'b1, "ignored_start");
        dones  = 0;
        busies = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busies++;
        end
        check("ignored_start extra_done", dones, 0);
        check("ignored_start extra_busy", busies, 0);
        check("ignored_start result_held", int'(result), int'(e.res));

        // Back-to-back: second start raised in the done cycle.
        e  = model(2'b01, 5'b10011, 5'b00111);
        e2 = model(2'b10, 5'b01010, 5'b00000);
        do_op(2'b01, 5'b10011, 5'b00111, e.res, e.cout, e.ovf, 1'b0, "b2b_first");
        do_op(2'b10, 5'b01010, 5'b00000, e2.res, e2.cout, e2.ovf, 1'b0, "b2b_second");
        idle_gap("b2b");

        // Put nonzero status in place, then reset at edge k+3 of a new run.
        do_op(2'b00, 5'b01111, 5'b00001, 5'b10000, 1'b0, 1'b1, 1'b0, "pre_reset");
        idle_gap("pre_reset");
        op    = 2'b01;
        a     = 5'b11000;
        b     = 5'b00011;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("mid_run_reset");
        rst_n    = 1'b1;
        last_res = '0;
        last_c   = 1'b0;
        last_v   = 1'b0;
        dones    = 0;
        busies   = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busies++;
        end
        check("mid_run_reset no_done", dones, 0);
        check("mid_run_reset no_busy", busies, 0);
        e = model(2'b00, 5'b01010, 5'b01011);
        do_op(2'b00, 5'b01010, 5'b01011, e.res, e.cout, e.ovf, 1'b0, "after_reset");
        idle_gap("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract/negate unit: one shared 1-bit full-adder slice, sequenced LSB-first over WIDTH cycles by a small FSM.
- Gives the team's combinational two's-complement and ripple-adder datapath a clocked, handshaked front end, one bit per clock.
- Used wherever area matters more than latency; a start/done handshake lets an upstream sequencer chain operations.

Parameters:
- WIDTH, 5, operand and result width in bits; must be >= 2.
- CNT_W, 3, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- start  input  1  request; accepted only when busy=0.
- op  input  2  00 = a+b, 01 = a-b, 10 = -a (two's complement), 11 = ~a (one's complement).
- a  input  WIDTH  operand A; sampled only at acceptance.
- b  input  WIDTH  operand B; sampled only at acceptance; ignored for op 10/11.
- busy  output  1  high while the FSM is in RUN.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  last completed result; held until the next completion.
- carry_out  output  1  carry out of the MSB slice for the last operation.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy, done, result, carry_out, overflow, internal shift registers and counter all 0.
  - Reset wins over every other input, including mid-RUN; a partial operation is discarded with no done pulse.
- FSM has two states, IDLE and RUN.
- IDLE, start=1 at edge k: operands are latched into two shift registers (SA, SB) and the FSM goes to RUN.
  - SA = a for op 00/01; SA = ~a for op 10/11.
  - SB = b for op 00; ~b for op 01; 0 for op 10/11.
  - Initial carry = 1 for op 01/10; 0 for op 00/11.
  - Counter=0, busy=1 from edge k.
- RUN, each edge: the slice computes sum = SA[0]^SB[0]^c and cout = majority(SA[0], SB[0], c).
  - sum shifts into the MSB end of the internal result shift register.
  - SA and SB shift right; c <= cout; counter increments.
  - Before the final slice, the carry into the MSB is saved for the overflow calculation.
- Last RUN edge (counter = WIDTH-1), which is edge k+WIDTH:
  - result <= completed value; carry_out <= cout; overflow <= saved carry XOR cout.
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: start accepted at edge k gives done high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH cycles.
  - start=1 while done=1 is accepted (state is IDLE), giving back-to-back operations.
- start while busy=1: ignored, no queuing. Operand inputs changing during RUN have no effect.
- Arithmetic is modulo 2**WIDTH.
  - -0 = 0 with carry_out=1.
  - -(most-negative value) = most-negative value with overflow=1.
  - For op 11, carry_out=0 and overflow=0.
- result, carry_out and overflow change only at completion or reset, never mid-RUN.
- done is never high while busy is high.

Test Plan:
- Reset, then op=00, a=00101, b=00011, start pulse at edge k -> busy high for cycles k..k+4; done in the cycle after edge k+5; result=01000, carry_out=0, overflow=0.
- op=01, a=00101, b=00011 -> result=00010, carry_out=1, overflow=0. Then a=00011, b=00101 -> result=11110, carry_out=0.
- op=10 over a = 00000/00001/00101/01111/10000/11111 -> results 00000/11111/11011/10001/10000/00001; overflow=1 only for a=10000.
- op=00, a=01111, b=00001 -> result=10000, overflow=1. op=11, a=00101 -> result=11010, overflow=0.
- Extra start with different operands at edge k+2 while busy -> ignored; first result unchanged; exactly one done pulse. A second start in the done cycle -> accepted, its done arrives 5 cycles later.
- rst_n=0 at edge k+3 mid-RUN -> all outputs 0, no done pulse; a new start after release completes correctly.
